// File: rtl/symbol_pacer.sv
// symbol_pacer: prefetches {I,Q} symbols from the CDC FIFO and emits one every
// 4*(sample_rate+1) cycles, inserting zero symbols when the FIFO starves.
module symbol_pacer #(
  parameter int SYM_W  = 8,
  parameter int SCNT_W = 16,
  parameter int UCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [3:0]        sample_rate,
  input  logic              fifo_empty,
  input  logic [SYM_W-1:0]  fifo_data,
  output logic              fifo_rd_en,
  output logic [3:0]        data_out_i,
  output logic [3:0]        data_out_q,
  output logic              new_symbol,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt,
  output logic [SCNT_W-1:0] symbol_cnt,
  input  logic              stat_clr
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state_q, state_d;
  logic [SYM_W-1:0] buf_q, buf_d, out_q, out_d;
  logic full_q, full_d, pend_q, new_q, new_d, und_q, und_d;
  logic [5:0] cnt_q, cnt_d, per_q, per_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic bnd, go_run, take_buf, bypass, zero;
  always_comb begin
    bnd        = enable && state_q == RUN && cnt_q == per_q;
    go_run     = enable && state_q == PRIME && (full_q || pend_q);
    fifo_rd_en = enable && state_q != IDLE && !full_q && !pend_q && !fifo_empty;
    take_buf   = bnd && full_q;
    bypass     = bnd && !full_q && pend_q;
    zero       = bnd && !full_q && !pend_q;
    state_d    = !enable ? IDLE : state_q == IDLE ? PRIME : go_run ? RUN : state_q;
    cnt_d      = (!enable || state_q != RUN || bnd) ? 6'd0 : cnt_q + 6'd1;
    per_d      = (go_run || bnd) ? {sample_rate, 2'b11} : per_q;
    // a returning read lands in the buffer unless it was consumed by a bypass
    full_d     = (pend_q && !bypass) ? 1'b1 : take_buf ? 1'b0 : full_q;
    buf_d      = (pend_q && !bypass) ? fifo_data : buf_q;
    out_d      = take_buf ? buf_q : bypass ? fifo_data : zero ? '0 : out_q;
    new_d      = bnd;
    und_d      = !stat_clr && (und_q || zero);
    ucnt_d     = stat_clr ? '0 : ucnt_q + UCNT_W'(zero && ucnt_q != '1);
    scnt_d     = stat_clr ? '0 : scnt_q + SCNT_W'(take_buf || bypass);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      out_q   <= '0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
      new_q   <= 1'b0;
      und_q   <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
      ucnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      full_q  <= full_d;
      pend_q  <= fifo_rd_en;
      new_q   <= new_d;
      und_q   <= und_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ucnt_q  <= ucnt_d;
      scnt_q  <= scnt_d;
    end
  end
  assign data_out_i   = out_q[7:4];
  assign data_out_q   = out_q[3:0];
  assign new_symbol   = new_q;
  assign underrun     = und_q;
  assign underrun_cnt = ucnt_q;
  assign symbol_cnt   = scnt_q;
endmodule
